// File: rtl/fifo_rd_drain.sv
// Read-side drain engine for async_fifo: pops words and presents them on a
// valid/ready stream through a 2-entry buffer that hides the FIFO read latency.
module fifo_rd_drain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             rd_clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_error_i,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic             err_o,
  output logic [CNT_W-1:0] pop_cnt_o
);

  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             r_err;
  logic [CNT_W-1:0] r_pop_cnt;

  logic             w_deq;
  logic [1:0]       w_occ_after;
  logic [2:0]       w_occ_nxt;

  // Occupancy after this cycle's dequeue plus the word already in flight is
  // both the credit check for a new pop and next cycle's occupancy.
  always_comb begin
    w_deq        = (r_occ != 2'd0) & m_ready_i;
    w_occ_after  = r_occ - {1'b0, w_deq};
    w_occ_nxt    = {1'b0, w_occ_after} + {2'b00, r_inflight};
    fifo_rd_en_o = en_i & ~fifo_empty_i & ~rst_i & (w_occ_nxt < 3'd2);
  end

  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_err      <= 1'b0;
      r_pop_cnt  <= '0;
    end else begin
      assert (w_occ_nxt <= 3'd2);
      r_inflight <= fifo_rd_en_o;
      r_occ      <= w_occ_nxt[1:0];
      if (w_deq && (r_occ == 2'd2))
        r_head <= r_tail;
      // Arriving word goes to head only if the buffer is empty after the dequeue
      if (r_inflight) begin
        if (w_occ_after == 2'd0)
          r_head <= fifo_rdata_i;
        else
          r_tail <= fifo_rdata_i;
      end
      if (fifo_error_i)
        r_err <= 1'b1;
      if (fifo_rd_en_o)
        r_pop_cnt <= r_pop_cnt + CNT_W'(1);
    end
  end

  assign m_valid_o = (r_occ != 2'd0);
  assign m_data_o  = r_head;
  assign err_o     = r_err;
  assign pop_cnt_o = r_pop_cnt;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: behavioural FIFO model feeds the DUT, a scoreboard
// queue holds written words in order and is checked on every output handshake.
module tb_fifo_rd_drain;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         rdy = 1'b0;
  logic         f_empty = 1'b1;
  logic         f_err = 1'b0;
  logic [W-1:0] f_rdata = '0;

  logic         rd_en, m_valid, err;
  logic [W-1:0] m_data;
  logic [15:0]  pop_cnt;
  logic         rd_en4, m_valid4, err4;
  logic [W-1:0] m_data4;
  logic [3:0]   pop_cnt4;

  fifo_rd_drain #(.WIDTH(W), .CNT_W(16)) dut (
    .rd_clk_i(clk), .rst_i(rst), .en_i(en), .fifo_rd_en_o(rd_en),
    .fifo_rdata_i(f_rdata), .fifo_empty_i(f_empty), .fifo_error_i(f_err),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(rdy),
    .err_o(err), .pop_cnt_o(pop_cnt)
  );

  fifo_rd_drain #(.WIDTH(W), .CNT_W(4)) dut4 (
    .rd_clk_i(clk), .rst_i(rst), .en_i(en), .fifo_rd_en_o(rd_en4),
    .fifo_rdata_i(f_rdata), .fifo_empty_i(f_empty), .fifo_error_i(f_err),
    .m_valid_o(m_valid4), .m_data_o(m_data4), .m_ready_i(rdy),
    .err_o(err4), .pop_cnt_o(pop_cnt4)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int pops = 0;
  int pops_sr = 0;
  int dlv = 0;
  int cyc = 0;
  int first_deq = -1;
  int last_deq = -1;
  logic rd_s = 1'b0;
  logic v_s = 1'b0;
  logic [W-1:0] d_s = '0;

  // One clock cycle: sample at negedge, advance the FIFO model after posedge.
  task automatic tick();
    logic [W-1:0] e;
    cyc++;
    @(negedge clk);
    rd_s = rd_en;
    v_s  = m_valid;
    d_s  = m_data;
    n_vec++;
    if ({rd_en4, m_valid4, m_data4} !== {rd_en, m_valid, m_data}) begin
      n_err++;
      $display("FAIL lockstep: cnt4 instance %b/%b/%h, required %b/%b/%h",
               rd_en4, m_valid4, m_data4, rd_en, m_valid, m_data);
    end
    if (rd_s) begin
      n_vec++;
      if (fq.size() == 0) begin
        n_err++;
        $display("FAIL underflow: rd_en=1 on empty FIFO, required 0");
      end
    end
    if (m_valid && rdy) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_word: got %h, required no word", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_err++;
          $display("FAIL order: got %h, required %h", m_data, e);
        end
      end
      dlv++;
      if (first_deq < 0) first_deq = cyc;
      last_deq = cyc;
    end
    @(posedge clk);
    #1;
    if (rst) pops_sr = 0;
    if (rd_s && fq.size() > 0) begin
      f_rdata = fq.pop_front();
      pops++;
      pops_sr++;
    end
    f_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    f_empty = 1'b0;
  endtask

  task automatic drain(input int budget, input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0 || fq.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d words left, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({rd_en, m_valid, m_data, err, pop_cnt, pop_cnt4} !== '0) begin
      n_err++;
      $display("FAIL reset: rd_en=%b valid=%b data=%h err=%b cnt=%0d cnt4=%0d, required all 0",
               rd_en, m_valid, m_data, err, pop_cnt, pop_cnt4);
    end
  endtask

  task automatic test_burst();
    int c0;
    for (int i = 0; i < 16; i++) push(W'($urandom));
    first_deq = -1;
    dlv = 0;
    c0 = cyc;
    en = 1'b1;
    rdy = 1'b1;
    drain(60, "burst");
    tick();
    n_vec++;
    if (first_deq - c0 != 3) begin
      n_err++;
      $display("FAIL burst_latency: first word at cycle %0d, required %0d", first_deq - c0, 3);
    end
    n_vec++;
    if (last_deq - first_deq != 15 || dlv != 16) begin
      n_err++;
      $display("FAIL burst_rate: %0d words over span %0d, required 16 over 15", dlv, last_deq - first_deq);
    end
    n_vec++;
    if (rd_s !== 1'b0) begin
      n_err++;
      $display("FAIL burst_stop: rd_en=%b after empty, required 0", rd_s);
    end
    n_vec++;
    if (pop_cnt !== 16'd16 || pop_cnt4 !== 4'd0) begin
      n_err++;
      $display("FAIL burst_cnt: cnt=%0d cnt4=%0d, required 16 and 0", pop_cnt, pop_cnt4);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    logic [W-1:0] w0;
    rdy = 1'b0;
    p0 = pops;
    w0 = 8'hA5;
    push(w0);
    for (int i = 1; i < 16; i++) push(W'($urandom));
    dlv = 0;
    repeat (10) tick();
    n_vec++;
    if (pops - p0 != 2) begin
      n_err++;
      $display("FAIL bp_pops: %0d pops, required 2", pops - p0);
    end
    n_vec++;
    if (v_s !== 1'b1 || d_s !== w0) begin
      n_err++;
      $display("FAIL bp_hold: valid=%b data=%h, required 1 %h", v_s, d_s, w0);
    end
    n_vec++;
    if (pop_cnt !== 16'(pops_sr)) begin
      n_err++;
      $display("FAIL bp_cnt: cnt=%0d, required %0d", pop_cnt, pops_sr);
    end
    for (int k = 0; k < 100 && (exp_q.size() != 0 || fq.size() != 0); k++) begin
      rdy = ~rdy;
      tick();
    end
    n_vec++;
    if (dlv != 16 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_total: %0d delivered with %0d pending, required 16 and 0", dlv, exp_q.size());
    end
  endtask

  task automatic test_enable();
    int p0;
    logic [W-1:0] w0;
    en = 1'b0;
    rdy = 1'b0;
    repeat (2) tick();
    p0 = pops;
    w0 = 8'h3C;
    push(w0);
    for (int i = 1; i < 8; i++) push(W'($urandom));
    repeat (20) tick();
    n_vec++;
    if (pops != p0 || v_s !== 1'b0) begin
      n_err++;
      $display("FAIL en_gate: %0d pops valid=%b, required 0 pops valid=0", pops - p0, v_s);
    end
    en = 1'b1;
    tick();
    n_vec++;
    if (rd_s !== 1'b1 || v_s !== 1'b0) begin
      n_err++;
      $display("FAIL en_cycle0: rd_en=%b valid=%b, required 1 0", rd_s, v_s);
    end
    tick();
    n_vec++;
    if (v_s !== 1'b0) begin
      n_err++;
      $display("FAIL en_cycle1: valid=%b, required 0", v_s);
    end
    tick();
    n_vec++;
    if (v_s !== 1'b1 || d_s !== w0) begin
      n_err++;
      $display("FAIL en_cycle2: valid=%b data=%h, required 1 %h", v_s, d_s, w0);
    end
    rdy = 1'b1;
    drain(40, "en");
  endtask

  task automatic test_reset_mid();
    int p0, lost, k;
    p0 = pops;
    for (int i = 0; i < 10; i++) push(W'($urandom));
    en = 1'b1;
    rdy = 1'b1;
    dlv = 0;
    k = 0;
    while (dlv < 5 && k < 40) begin
      tick();
      k++;
    end
    rdy = 1'b0;
    lost = (pops - p0) - dlv;
    n_vec++;
    if (dlv != 5 || lost != 2) begin
      n_err++;
      $display("FAIL mid_lost: delivered %0d lost %0d, required 5 and 2", dlv, lost);
    end
    for (int i = 0; i < lost && exp_q.size() > 0; i++) void'(exp_q.pop_front());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (m_valid !== 1'b0 || pop_cnt !== 16'd0 || rd_en !== (fq.size() != 0)) begin
      n_err++;
      $display("FAIL mid_reset: valid=%b cnt=%0d rd_en=%b, required 0 0 %b",
               m_valid, pop_cnt, rd_en, fq.size() != 0);
    end
    rdy = 1'b1;
    drain(40, "mid");
    n_vec++;
    if (dlv != 10 - lost) begin
      n_err++;
      $display("FAIL mid_total: %0d delivered, required %0d", dlv, 10 - lost);
    end
  endtask

  task automatic test_err_wrap();
    rst = 1'b1;
    rdy = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) push(W'($urandom));
    en = 1'b1;
    rdy = 1'b1;
    drain(60, "wrap");
    tick();
    n_vec++;
    if (pop_cnt !== 16'd17 || pop_cnt4 !== 4'd1) begin
      n_err++;
      $display("FAIL wrap_cnt: cnt=%0d cnt4=%0d, required 17 and 1", pop_cnt, pop_cnt4);
    end
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_idle: err=%b, required 0", err);
    end
    f_err = 1'b1;
    tick();
    f_err = 1'b0;
    #1;
    n_vec++;
    if (err !== 1'b1 || err4 !== 1'b1) begin
      n_err++;
      $display("FAIL err_set: err=%b err4=%b, required 1 1", err, err4);
    end
    repeat (5) tick();
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: err=%b, required 1", err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (err !== 1'b0 || pop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL err_clear: err=%b cnt=%0d, required 0 0", err, pop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_err_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
